// File: rtl/rgb_frame_reader.sv
// Streams a packed RGB frame (3 SRAM words per pixel pair) from SRAM to a
// valid/ready pixel consumer through a small FIFO, in raster order.
module rgb_frame_reader #(
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int          NUM_PIXELS = 76800,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  localparam int PAIRS = NUM_PIXELS / 2;
  localparam int CW    = $clog2(NUM_PIXELS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FCW   = AW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, ISSUE2, DRAIN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_W0, TAG_W1, TAG_W2} tag_t;

  state_t          state_reg;
  tag_t            tag_d1_reg, tag_d2_reg;
  logic [CW-1:0]   pair_cnt_reg;
  logic [CW-1:0]   pix_cnt_reg;
  logic [FCW-1:0]  pending_reg;
  logic [FCW-1:0]  fifo_count_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [7:0]      r0_reg, g0_reg, r1_reg;
  logic [24:0]     fifo_mem [FIFO_DEPTH];
  logic [24:0]     head;

  logic            space;
  logic            issue0;
  logic            start_accept;
  logic            push, pop;
  logic [23:0]     push_data;
  logic            push_last;
  logic            last_pop;

  // Budget counts pixels already buffered plus those still in flight, so a
  // newly issued pair can never find the FIFO full when its words land.
  assign space        = (int'(fifo_count_reg) + int'(pending_reg)) <= (FIFO_DEPTH - 2);
  assign issue0       = (state_reg == ISSUE0) && space;
  assign start_accept = (state_reg == IDLE) && start && !done;

  assign push      = (tag_d2_reg == TAG_W1) || (tag_d2_reg == TAG_W2);
  assign push_data = (tag_d2_reg == TAG_W1) ? {r0_reg, g0_reg, SRAM_read_data[15:8]}
                                            : {r1_reg, SRAM_read_data};
  assign push_last = (pix_cnt_reg == CW'(NUM_PIXELS - 1));

  assign head      = fifo_mem[rd_ptr_reg];
  assign pix_valid = (fifo_count_reg != '0);
  assign pop       = pix_valid && pix_ready;
  assign last_pop  = pop && head[24];

  assign pix_R     = head[23:16];
  assign pix_G     = head[15:8];
  assign pix_B     = head[7:0];
  assign pix_last  = pix_valid && head[24];
  assign SRAM_we_n = 1'b1;

  // Fetch FSM: one address per cycle, tags follow the address by one cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg    <= IDLE;
      SRAM_address <= RGB_BASE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pair_cnt_reg <= '0;
      tag_d1_reg   <= TAG_NONE;
    end else begin
      done       <= 1'b0;
      tag_d1_reg <= TAG_NONE;
      case (state_reg)
        IDLE: begin
          if (start_accept) begin
            state_reg    <= ISSUE0;
            busy         <= 1'b1;
            pair_cnt_reg <= '0;
            SRAM_address <= RGB_BASE;
          end
        end
        ISSUE0: begin
          if (space) begin
            tag_d1_reg   <= TAG_W0;
            SRAM_address <= SRAM_address + 18'd1;
            state_reg    <= ISSUE1;
          end
        end
        ISSUE1: begin
          tag_d1_reg   <= TAG_W1;
          SRAM_address <= SRAM_address + 18'd1;
          state_reg    <= ISSUE2;
        end
        ISSUE2: begin
          tag_d1_reg <= TAG_W2;
          // Final pair leaves the address on its last word; stepping past it
          // would wrap the 18-bit address for a frame ending at the top.
          if (pair_cnt_reg == CW'(PAIRS - 1)) begin
            state_reg <= DRAIN;
          end else begin
            pair_cnt_reg <= pair_cnt_reg + CW'(1);
            SRAM_address <= SRAM_address + 18'd1;
            state_reg    <= ISSUE0;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            done         <= 1'b1;
            busy         <= 1'b0;
            state_reg    <= IDLE;
            SRAM_address <= RGB_BASE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Capture pipeline and FIFO bookkeeping.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tag_d2_reg     <= TAG_NONE;
      r0_reg         <= '0;
      g0_reg         <= '0;
      r1_reg         <= '0;
      pending_reg    <= '0;
      pix_cnt_reg    <= '0;
      fifo_count_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      tag_d2_reg <= tag_d1_reg;
      if (tag_d2_reg == TAG_W0) begin
        r0_reg <= SRAM_read_data[15:8];
        g0_reg <= SRAM_read_data[7:0];
      end
      if (tag_d2_reg == TAG_W1) begin
        r1_reg <= SRAM_read_data[7:0];
      end

      if (start_accept) begin
        pending_reg <= '0;
        pix_cnt_reg <= '0;
      end else begin
        pending_reg <= pending_reg + (issue0 ? FCW'(2) : FCW'(0)) - (push ? FCW'(1) : FCW'(0));
        if (push) begin
          pix_cnt_reg <= pix_cnt_reg + CW'(1);
        end
      end

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + FCW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - FCW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // FIFO storage; bit 24 flags the frame's final pixel.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr_reg] <= {push_last, push_data};
    end
  end

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Directed bench for rgb_frame_reader using a reduced frame size and a
// 2-cycle-latency SRAM model; pixels are checked against the packing rule.
module tb_rgb_frame_reader;

  localparam logic [17:0] BASE     = 18'd146944;
  localparam int          N        = 240;
  localparam int          DEPTH    = 8;
  localparam logic [17:0] MAX_ADDR = BASE + 18'(3 * N / 2 - 1);

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic [15:0] SRAM_read_data = 16'h0;
  logic [15:0] rd_pipe = 16'h0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [7:0]  pix_R, pix_G, pix_B;
  logic        pix_valid, pix_last, busy, done;

  int checks = 0;
  int errors = 0;

  rgb_frame_reader #(
    .RGB_BASE   (BASE),
    .NUM_PIXELS (N),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .start          (start),
    .SRAM_address   (SRAM_address),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_we_n      (SRAM_we_n),
    .pix_R          (pix_R),
    .pix_G          (pix_G),
    .pix_B          (pix_B),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_last       (pix_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [17:0] a);
    if (a == BASE)          return 16'hAA11;
    if (a == BASE + 18'd1)  return 16'h22BB;
    if (a == BASE + 18'd2)  return 16'hCC33;
    return 16'(a - BASE) + 16'h1000;
  endfunction

  function automatic logic [23:0] exp_pix(input int i);
    logic [17:0] a;
    logic [15:0] w0, w1, w2;
    a  = BASE + 18'(3 * (i / 2));
    w0 = word_at(a);
    w1 = word_at(a + 18'd1);
    w2 = word_at(a + 18'd2);
    if (i % 2 == 0) return {w0, w1[15:8]};
    return {w1[7:0], w2};
  endfunction

  // SRAM: data for the address presented in cycle t is on the bus in cycle t+2.
  always @(posedge Clock) begin
    rd_pipe        <= word_at(SRAM_address);
    SRAM_read_data <= rd_pipe;
  end

  bit          mon_en = 1'b0;
  int          exp_idx = 0, accepted = 0, done_cnt = 0, last_cnt = 0;
  bit          prev_last_pop = 1'b0, prev_stall = 1'b0, frame_done = 1'b0;
  logic [23:0] prev_pix = '0, cur_pix;
  logic [17:0] max_addr = '0;

  always @(negedge Clock) begin
    if (mon_en && Resetn) begin
      cur_pix = {pix_R, pix_G, pix_B};
      if (prev_stall) check("hold_stable", cur_pix, prev_pix);
      if (prev_last_pop) begin
        check("done_after_last", done, 1);
        check("busy_after_last", busy, 0);
      end
      check("push_into_full", (dut.push && (dut.fifo_count_reg == DEPTH)), 0);
      if (busy) begin
        check("addr_bound", (SRAM_address <= MAX_ADDR), 1);
        if (SRAM_address > max_addr) max_addr = SRAM_address;
      end
      if (done) begin
        done_cnt++;
        frame_done = 1'b1;
      end
      prev_last_pop = 1'b0;
      if (pix_valid && pix_ready) begin
        check("pixel", cur_pix, exp_pix(exp_idx));
        check("pix_last", pix_last, (exp_idx == N - 1));
        if (pix_last) last_cnt++;
        prev_last_pop = pix_last;
        exp_idx++;
        accepted++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = cur_pix;
    end
  end

  task automatic clear_monitor();
    exp_idx = 0; accepted = 0; done_cnt = 0; last_cnt = 0;
    prev_last_pop = 1'b0; prev_stall = 1'b0; frame_done = 1'b0;
    max_addr = '0;
  endtask

  task automatic start_frame();
    clear_monitor();
    @(posedge Clock); #1 start = 1'b1;
    @(posedge Clock); #1 start = 1'b0;
  endtask

  // Drives ready each cycle until done; optionally pokes start mid-frame and
  // in the done cycle, both of which must be ignored.
  task automatic run_frame(input string name, input bit rnd, input bit poke);
    int cyc;
    cyc = 0;
    while (!frame_done && cyc < 6000) begin
      @(posedge Clock); #1;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke && (done || (busy && $urandom_range(0, 19) == 0))) ? 1'b1 : 1'b0;
      cyc++;
    end
    start = 1'b0;
    pix_ready = 1'b1;
    check("frame_timeout", frame_done, 1);
    @(negedge Clock);
    @(negedge Clock);
    check("pixel_count", accepted, N);
    check("done_pulses", done_cnt, 1);
    check("last_count", last_cnt, 1);
    check("max_addr", max_addr, MAX_ADDR);
    check("busy_after", busy, 0);
    check("addr_home", SRAM_address, BASE);
    $display("frame %s: pixels=%0d done=%0d max_addr=%0d cycles=%0d", name, accepted, done_cnt, max_addr, cyc);
  endtask

  initial begin
    int cyc;
    // Reset state
    @(negedge Clock);
    check("rst_addr", SRAM_address, BASE);
    check("rst_we_n", SRAM_we_n, 1);
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", pix_last, 0);
    check("rst_rgb", {pix_R, pix_G, pix_B}, 0);
    @(posedge Clock); #1 Resetn = 1'b1;
    mon_en = 1'b1;

    // Unpacking and first-pixel latency
    pix_ready = 1'b1;
    start_frame();
    @(negedge Clock);
    check("t0_busy", busy, 1);
    check("t0_addr", SRAM_address, BASE);
    repeat (3) @(negedge Clock);
    check("t3_valid", pix_valid, 0);
    @(negedge Clock);
    check("t4_valid", pix_valid, 1);
    check("p0_R", pix_R, 8'hAA);
    check("p0_G", pix_G, 8'h11);
    check("p0_B", pix_B, 8'h22);
    @(negedge Clock);
    check("p1_RGB", {pix_R, pix_G, pix_B}, 24'hBBCC33);
    run_frame("unpack", 1'b0, 1'b0);

    // Back-pressure fills the FIFO and stalls the address
    pix_ready = 1'b0;
    start_frame();
    repeat (40) @(negedge Clock);
    check("bp_count", dut.fifo_count_reg, DEPTH);
    check("bp_addr", SRAM_address, BASE + 18'd12);
    check("bp_valid", pix_valid, 1);
    check("bp_head", {pix_R, pix_G, pix_B}, 24'hAA1122);
    run_frame("backpressure", 1'b0, 1'b0);

    // Random ready with stray start pulses
    start_frame();
    run_frame("random", 1'b1, 1'b1);
    @(negedge Clock);
    check("start_at_done_ignored", busy, 0);

    // Mid-frame reset, then restart from the first pair
    start_frame();
    cyc = 0;
    while (accepted < 100 && cyc < 3000) begin
      @(posedge Clock); #1 pix_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    check("reach_px100", (accepted >= 100), 1);
    #3 Resetn = 1'b0;
    #1;
    check("mid_rst_addr", SRAM_address, BASE);
    check("mid_rst_valid", pix_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fifo", dut.fifo_count_reg, 0);
    check("mid_rst_we_n", SRAM_we_n, 1);
    check("mid_rst_last", pix_last, 0);
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    pix_ready = 1'b1;
    start_frame();
    run_frame("restart", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_frame_reader.md
Name: rgb_frame_reader

Overview:
- Downstream neighbour of the YUV-to-RGB colourspace/upsampling stage.
- Reads the packed RGB frame that stage writes to external SRAM, unpacks it into 24-bit pixels, and streams them in raster order to the VGA pixel consumer.
- Uses a valid/ready handshake with a small pixel FIFO, so consumer back-pressure never loses data.
- Read-only SRAM master; owns the SRAM port only while busy.

Parameters:
- RGB_BASE, 18'd146944, SRAM word address of the first RGB word.
- NUM_PIXELS, 76800, pixels per frame (320x240); must be even.
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, minimum 4.

Ports:
- Clock  in  1  system clock
- Resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame read when idle
- SRAM_address  out  18  SRAM word address
- SRAM_read_data  in  16  SRAM read data, valid 2 cycles after the address
- SRAM_we_n  out  1  write enable, active-low; constant 1
- pix_R / pix_G / pix_B  out  8 each  head-of-FIFO pixel
- pix_valid  out  1  FIFO non-empty
- pix_ready  in  1  consumer accepts pixel when pix_valid & pix_ready
- pix_last  out  1  head pixel is pixel NUM_PIXELS-1
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset is Resetn, asynchronous, active-low; clock is Clock.
- Reset values:
  - SRAM_address = RGB_BASE, SRAM_we_n = 1.
  - pix_valid = 0, pix_last = 0, busy = 0, done = 0, pix_R/G/B = 0.
  - FIFO is emptied; all counters are 0.
- Packing: each pixel pair occupies 3 consecutive words.
  - w0 = {R0,G0}, w1 = {B0,R1}, w2 = {G1,B1}, with the high byte first.
  - Pair k sits at RGB_BASE+3k .. RGB_BASE+3k+2.
- Fetch FSM states: IDLE, ISSUE0, ISSUE1, ISSUE2, DRAIN.
  - IDLE + start → ISSUE0; sets busy = 1 and clears pair/pixel counters. start while busy is ignored.
  - ISSUE0 is entered only when (fifo_count + pending_pixels) <= FIFO_DEPTH-2; otherwise the FSM holds in ISSUE0 with no address advance.
  - ISSUE0/1/2 each present one address in consecutive cycles, and pending_pixels increases by 2 at ISSUE0.
  - After ISSUE2: if pairs remain and there is space, go directly to ISSUE0, giving back-to-back groups and a peak rate of 2 pixels per 3 cycles.
  - After the final pair's ISSUE2 → DRAIN.
- Data capture pipeline, using a 2-stage delay of the issue tags:
  - w0 arrives: latch R0, G0.
  - w1 arrives: push pixel {R0,G0,B0}; latch R1.
  - w2 arrives: push {R1,G1,B1}.
  - Each push decrements pending_pixels.
- FIFO behaviour:
  - A pop occurs when pix_valid & pix_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - The space check guarantees no push when full; a push into a full FIFO is a design error and gets an assertion in the bench.
  - Output data is the registered FIFO head and is stable while pix_valid & ~pix_ready.
- pix_last is tracked per FIFO entry and is set on pixel index NUM_PIXELS-1 only.
- Completion:
  - In DRAIN, when the last pixel is popped: the cycle after the pop, done = 1 for one cycle, busy = 0, and the FSM returns to IDLE.
  - SRAM_address returns to RGB_BASE.
- Address rule: SRAM_address never exceeds RGB_BASE + 3*NUM_PIXELS/2 - 1, which is 146944 + 115199 = 262143 for the defaults.
- start coincident with the done pulse is ignored; start is accepted from the following cycle.
- Resetn asserted mid-frame: outputs immediately take reset values and FIFO contents are discarded; no partial resume.

Test Plan:
1. Reset values: assert Resetn=0 mid-operation → immediately SRAM_address = 146944, pix_valid = 0, busy = 0, FIFO empty, SRAM_we_n = 1.
2. Unpacking: words 0xAA11, 0x22BB, 0xCC33 at 146944..146946, pix_ready = 1 → first pixel (R,G,B) = (AA,11,22), second = (BB,CC,33); first pix_valid rises 4 cycles after the ISSUE0 address.
3. Back-pressure: pix_ready = 0 for 40 cycles after start → fifo_count reaches exactly 8, the address stalls at 146944+12, no push into full FIFO; on releasing ready, all pixels emerge in order with no gaps or duplicates.
4. Full frame: incrementing-pattern memory, random ready (50%) → exactly 76800 pixels accepted, last address read = 262143, pix_last only on pixel 76799, one done pulse, busy = 0 afterwards.
5. Start while busy: start pulses at random cycles mid-frame → ignored; pixel count and address sequence are unchanged.
6. Reset then restart: assert Resetn at pixel 1000, then issue start → the frame restarts from address 146944 and pixel 0 matches scenario 2 data.
